// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
// sram_bus_arbiter: merges the CPU fetch and data SRAM-style ports onto one req/ack/valid memory port.
// Latency: fetch-only with ack in the request cycle and valid one cycle later is 3 stall cycles, then 1 release cycle.
// Backpressure: request fields are held while mem_req=1 until mem_ack; the core is held through stall.
module sram_bus_arbiter #(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter logic [2:0] UNCACHED_SEG = 3'b101,
    parameter int         SEG_XLATE    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_ren,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_is_cache,
    input  logic                mem_ack,
    input  logic                mem_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        DWAIT = 3'd2,
        IREQ  = 3'd3,
        IWAIT = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic data_store;
    logic data_op;
    logic any_req;
    logic ld_data;
    logic ld_inst;
    logic cap_data;
    logic cap_inst;

    // Direct-mapped kernel segment (top bits 2'b10) drops its segment bits to form the physical address.
    function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] va);
        logic [ADDR_W-1:0] pa;
        pa = va;
        if ((SEG_XLATE != 0) && (va[ADDR_W-1 -: 2] == 2'b10)) begin
            pa[ADDR_W-1 -: 3] = 3'b000;
        end
        return pa;
    endfunction

    // Cacheability is decided on the virtual segment, before any translation.
    function automatic logic seg_cached(input logic [ADDR_W-1:0] va);
        return (va[ADDR_W-1 -: 3] != UNCACHED_SEG);
    endfunction

    // Request decode and pipeline hold; DONE is the single release cycle for the whole instruction.
    always_comb begin
        data_store = (data_wen != '0);
        data_op    = data_ren | data_store;
        any_req    = inst_req | data_op;
        stall      = any_req & (state != DONE);
        mem_req    = (state == DREQ) || (state == IREQ);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus field-load and response-capture strobes.
    always_comb begin
        state_nxt = state;
        ld_data   = 1'b0;
        ld_inst   = 1'b0;
        cap_data  = 1'b0;
        cap_inst  = 1'b0;
        case (state)
            IDLE: begin
                // A flush in IDLE just holds off issue; data always goes before the fetch.
                if (!flush) begin
                    if (data_op) begin
                        state_nxt = DREQ;
                        ld_data   = 1'b1;
                    end else if (inst_req) begin
                        state_nxt = IREQ;
                        ld_inst   = 1'b1;
                    end
                end
            end
            DREQ: begin
                // Loads and stores are never cancelled, so flush is not looked at here.
                if (mem_ack) begin
                    state_nxt = DWAIT;
                end
            end
            DWAIT: begin
                if (mem_valid) begin
                    cap_data = 1'b1;
                    if (inst_req) begin
                        state_nxt = IREQ;
                        ld_inst   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            IREQ: begin
                // Once accepted, a flushed fetch still owes a response that must be drained.
                if (mem_ack) begin
                    state_nxt = flush ? DRAIN : IWAIT;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            IWAIT: begin
                if (mem_valid) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        cap_inst  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_valid) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are loaded only when a request is issued, so they are frozen while mem_req is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr     <= '0;
            mem_wen      <= '0;
            mem_wdata    <= '0;
            mem_is_cache <= 1'b0;
        end else if (ld_data) begin
            mem_addr     <= xlate(data_addr);
            mem_wen      <= data_wen;
            mem_wdata    <= data_store ? data_wdata : '0;
            mem_is_cache <= seg_cached(data_addr);
        end else if (ld_inst) begin
            mem_addr     <= xlate(inst_addr);
            mem_wen      <= {BE_W{1'b0}};
            mem_wdata    <= '0;
            mem_is_cache <= seg_cached(inst_addr);
        end
    end

    // Read data registers hold until the next response captured for their own port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rdata <= '0;
            inst_rdata <= '0;
        end else begin
            if (cap_data) begin
                data_rdata <= mem_rdata;
            end
            if (cap_inst) begin
                inst_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
`timescale 1ns/1ps
// tb_sram_bus_arbiter: directed and randomized transactions against a transaction-level model.
// Memory side is emulated with programmable ack/valid delays; each instruction is checked end to end.
// Expected addresses, fields, stall counts and read data come from the address-map rules.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_ren;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_is_cache;
    logic        mem_ack;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_d = 32'h0;
    logic [31:0] model_i = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        cache;
        logic [31:0] resp;
    } req_t;

    sram_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .data_ren     (data_ren),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_is_cache (mem_is_cache),
        .mem_ack      (mem_ack),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address map: 0x8000_0000..0xBFFF_FFFF is direct-mapped onto 0x0000_0000..0x1FFF_FFFF.
    function automatic logic [31:0] phys(input logic [31:0] a);
        return (a >= 32'h8000_0000 && a < 32'hC000_0000) ? (a & 32'h1FFF_FFFF) : a;
    endfunction

    // Only 0xA000_0000..0xBFFF_FFFF is uncached.
    function automatic logic cacheable(input logic [31:0] a);
        return !(a >= 32'hA000_0000 && a < 32'hC000_0000);
    endfunction

    task automatic drop_inputs();
        inst_req   = 1'b0;
        data_ren   = 1'b0;
        data_wen   = 4'h0;
        flush      = 1'b0;
    endtask

    // One core instruction: optional data op then optional fetch, memory answering with fixed delays.
    task automatic do_op(input logic ireq, input logic [31:0] iaddr, input logic ren,
                         input logic [3:0] wen, input logic [31:0] daddr, input logic [31:0] wdat,
                         input int ackd, input int vald, input logic [31:0] rd_d,
                         input logic [31:0] rd_i, input string tag);
        req_t q[$];
        req_t r;
        int   exp_stall;
        int   stalls;
        int   rc;
        int   wc;
        int   phase;
        bit   done;
        bit   dop;
        dop = ren || (wen != 4'h0);
        if (dop) begin
            r.addr = phys(daddr); r.wen = wen; r.wdata = (wen != 4'h0) ? wdat : 32'h0;
            r.cache = cacheable(daddr); r.resp = rd_d;
            q.push_back(r);
        end
        if (ireq) begin
            r.addr = phys(iaddr); r.wen = 4'h0; r.wdata = 32'h0;
            r.cache = cacheable(iaddr); r.resp = rd_i;
            q.push_back(r);
        end
        exp_stall = 1 + q.size() * (ackd + vald + 2);
        @(negedge clk);
        inst_req = ireq; inst_addr = iaddr; data_ren = ren; data_wen = wen;
        data_addr = daddr; data_wdata = wdat; flush = 1'b0;
        stalls = 0; phase = 0; rc = 0; wc = 0; done = 1'b0;
        for (int guard = 0; guard < 200 && !done; guard++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                chk({tag, "_req_in_done"}, mem_req, 1'b0);
            end else begin
                stalls++;
                if (phase == 0 && mem_req) begin
                    if (q.size() == 0) begin
                        chk({tag, "_extra_req"}, mem_req, 1'b0);
                    end else begin
                        chk({tag, "_fields"}, {mem_addr, mem_wen, mem_wdata, mem_is_cache},
                            {q[0].addr, q[0].wen, q[0].wdata, q[0].cache});
                        if (rc == ackd) begin
                            mem_ack = 1'b1; phase = 1; wc = 0;
                        end else begin
                            rc++;
                        end
                    end
                end else if (phase == 1) begin
                    chk({tag, "_req_low_wait"}, mem_req, 1'b0);
                    if (wc == vald) begin
                        mem_valid = 1'b1; mem_rdata = q[0].resp;
                        void'(q.pop_front());
                        phase = 0; rc = 0;
                    end else begin
                        wc++;
                    end
                end
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = $urandom;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
        chk({tag, "_all_issued"}, q.size(), 0);
        if (dop) model_d = rd_d;
        if (ireq) model_i = rd_i;
        chk({tag, "_data_rdata"}, data_rdata, model_d);
        chk({tag, "_inst_rdata"}, inst_rdata, model_i);
        // Inputs still held one cycle after release: the arbiter is back in IDLE and stalls again.
        if (done) chk({tag, "_stall_one_cycle"}, stall, 1'b1);
        drop_inputs();
    endtask

    initial begin
        logic [31:0] a1, a2, wd, r1, r2, saved_i;
        logic [3:0]  we;
        int          kind;

        rst = 1'b1;
        drop_inputs();
        inst_addr = '0; data_addr = '0; data_wdata = '0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {mem_req, mem_addr, mem_wen, mem_wdata, mem_is_cache, stall},
            {1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0});
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Uncached boot fetch.
        do_op(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h2408_0001, "fetch_boot");

        // Partial store plus fetch: store goes first, single release after the fetch.
        do_op(1'b1, 32'h8000_0040, 1'b0, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF, 0, 0,
              32'h1111_2222, 32'h3C01_0000, "store_fetch");

        // Load with slow acceptance: fields checked on each of the 4 request cycles.
        do_op(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_2000, 32'hFFFF_FFFF, 3, 1,
              32'hCAFE_F00D, 32'h0, "load_slow_ack");

        // Randomized instruction mix across all segments and delays.
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 3);
            a1 = $urandom; a2 = $urandom; wd = $urandom; r1 = $urandom; r2 = $urandom;
            we = 4'($urandom_range(1, 15));
            case (kind)
                0: do_op(1'b1, a1, 1'b0, 4'h0, a2, wd, $urandom_range(0, 3), $urandom_range(0, 3), r1, r2, "rnd_fetch");
                1: do_op(1'b0, a1, 1'b1, 4'h0, a2, wd, $urandom_range(0, 3), $urandom_range(0, 3), r1, r2, "rnd_load");
                2: do_op(1'b0, a1, 1'b0, we, a2, wd, $urandom_range(0, 3), $urandom_range(0, 3), r1, r2, "rnd_store");
                default: do_op(1'b1, a1, 1'b1, 4'h0, a2, wd, $urandom_range(0, 3), $urandom_range(0, 3), r1, r2, "rnd_load_fetch");
            endcase
        end

        // Flush while waiting on a fetch response: response drained, inst_rdata kept.
        saved_i = model_i;
        @(negedge clk); inst_req = 1'b1; inst_addr = 32'h9000_0100;          // IDLE
        @(negedge clk); #1 chk("fl_ireq", mem_req, 1'b1); mem_ack = 1'b1;     // IREQ accepted
        @(negedge clk); mem_ack = 1'b0; flush = 1'b1;                         // IWAIT + flush
        #1 chk("fl_iwait_req", mem_req, 1'b0);
        @(negedge clk); flush = 1'b0;                                         // DRAIN
        #1 chk("fl_drain_stall", {stall, mem_req}, 2'b10);
        @(negedge clk); mem_valid = 1'b1; mem_rdata = 32'h1234_5678;          // late response
        @(negedge clk); mem_valid = 1'b0; inst_addr = 32'h0040_0200;          // back in IDLE
        #1 chk("fl_inst_kept", inst_rdata, saved_i);
        chk("fl_idle_req", mem_req, 1'b0);
        @(negedge clk); #1                                                    // refetch issued
        chk("fl_refetch", {mem_req, mem_addr, mem_is_cache}, {1'b1, phys(32'h0040_0200), cacheable(32'h0040_0200)});
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        #1 mem_valid = 1'b1; mem_rdata = 32'h0800_0000;
        @(negedge clk); mem_valid = 1'b0;
        #1 chk("fl_refetch_done", {stall, inst_rdata}, {1'b0, 32'h0800_0000});
        model_i = 32'h0800_0000;
        drop_inputs();

        // Flush during a load is ignored.
        @(negedge clk); data_ren = 1'b1; data_addr = 32'hA000_0010;           // IDLE
        @(negedge clk); flush = 1'b1;                                         // DREQ, no ack
        #1 chk("fd_dreq", {mem_req, mem_addr, mem_is_cache}, {1'b1, 32'h0000_0010, 1'b0});
        @(negedge clk); mem_ack = 1'b1;                                       // still DREQ
        #1 chk("fd_dreq_hold", mem_req, 1'b1);
        @(negedge clk); mem_ack = 1'b0;                                       // DWAIT
        #1 chk("fd_dwait", {mem_req, stall}, 2'b01);
        @(negedge clk); mem_valid = 1'b1; mem_rdata = 32'h5A5A_0F0F;
        @(negedge clk); mem_valid = 1'b0; flush = 1'b0;
        #1 chk("fd_done", {stall, data_rdata}, {1'b0, 32'h5A5A_0F0F});
        model_d = 32'h5A5A_0F0F;
        drop_inputs();

        // Reset in the middle of a store, then a stray response in IDLE.
        @(negedge clk); data_wen = 4'hF; data_addr = 32'h8000_2000; data_wdata = 32'h0BAD_F00D;
        @(negedge clk); #1 chk("rs_dreq", mem_req, 1'b1); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("rs_dwait_addr", mem_addr, 32'h0000_2000);
        #1 rst = 1'b1; drop_inputs();
        #1 chk("rs_async_out", {mem_req, mem_addr, mem_wen, mem_wdata, mem_is_cache, stall},
               {1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0});
        chk("rs_async_rdata", {inst_rdata, data_rdata}, 64'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mem_valid = 1'b1; mem_rdata = 32'hFEED_FACE;
        @(negedge clk); mem_valid = 1'b0;
        #1 chk("rs_stray_ignored", {inst_rdata, data_rdata, mem_req, stall}, {64'h0, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
